// File: rtl/sine_generator.sv
// Purpose : Free-running sine and inverted-sine sample generator driven by a
//           phase counter, with the sample table built from constants at elaboration.
// Latency : The outputs are registered and update on the same edge as signal_cnt.
//           There is no added pipeline delay.
// Backpressure: None. The en input stalls the phase, and all outputs hold while en is low.
//
// Ports:
//   clk          - single clock; all state changes on its rising edge
//   rst          - synchronous active-high reset (phase 0, both outputs at midscale)
//   en           - advance enable; the phase steps only while high
//   sine_out     - current sample, unsigned offset-binary, SAMPLE_WIDTH bits
//   neg_sine_out - 180-degree-shifted sample (2^W - sine_out), SAMPLE_WIDTH bits
//   signal_cnt   - current phase index, log2(SAMPLE_NUMBER) bits
//
// Build option: define SINE_GEN_QUARTER_WAVE_EN to store only the first
// quadrant (0..pi/2). The other quadrants are derived by mirroring and inversion.
// Both builds produce bit-identical output sequences.
module sine_generator #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    output logic [SAMPLE_WIDTH-1:0]          sine_out,
    output logic [SAMPLE_WIDTH-1:0]          neg_sine_out,
    output logic [$clog2(SAMPLE_NUMBER)-1:0] signal_cnt
);
    localparam int CW  = $clog2(SAMPLE_NUMBER);
    localparam int MID = 1 << (SAMPLE_WIDTH - 1);
    localparam int AMP = MID - 1;

    localparam logic [SAMPLE_WIDTH-1:0] MID_W  = SAMPLE_WIDTH'(MID);
    localparam logic [SAMPLE_WIDTH-1:0] ZERO_W = '0;
    localparam logic [CW-1:0]           ZERO_C = '0;
    localparam logic [CW-1:0]           ONE_C  = CW'(1);

`ifdef SINE_GEN_QUARTER_WAVE_EN
    // Only entries 0..N/4 are ever addressed. The table is sized N/2 so that a
    // (CW-1)-bit index covers it exactly.
    localparam int RS = SAMPLE_NUMBER / 2;
    localparam logic [CW-1:0] HALF_C = CW'(SAMPLE_NUMBER / 2);
`else
    localparam int RS = SAMPLE_NUMBER;
`endif

    // Elaboration-time table entry: M + round(A*sin(2*pi*n/N)), rounding half
    // away from zero. The sine is evaluated in Q30 fixed point with a Taylor
    // series on the first-quadrant angle. Magnitude rounding is followed by
    // sign restoration, so the positive and negative half-waves are exact
    // mirrors of each other.
    function automatic logic [SAMPLE_WIDTH-1:0] calc_entry(input int n);
        longint pi_q30, nn, k, q, x, x2, term, acc, v, r;
        bit     neg;
        pi_q30 = 64'sd3373259426;           // round(pi * 2^30)
        nn     = longint'(SAMPLE_NUMBER);
        k      = longint'(n) % nn;
        if (4 * k <= nn) begin
            q = k;            neg = 1'b0;
        end else if (2 * k <= nn) begin
            q = nn / 2 - k;   neg = 1'b0;
        end else if (4 * k <= 3 * nn) begin
            q = k - nn / 2;   neg = 1'b1;
        end else begin
            q = nn - k;       neg = 1'b1;
        end
        x    = (2 * pi_q30 * q) / nn;       // angle in Q30, 0..pi/2
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int i = 1; i <= 8; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
            acc  = acc + term;
        end
        v = longint'(AMP) * acc;
        r = (v + 64'sd536870912) >>> 30;    // add 0.5 in Q30, then truncate
        if (neg) r = -r;
        return SAMPLE_WIDTH'(longint'(MID) + r);
    endfunction

    logic [SAMPLE_WIDTH-1:0] rom [RS];

    for (genvar g = 0; g < RS; g++) begin : g_rom
        localparam logic [SAMPLE_WIDTH-1:0] ENTRY = calc_entry(g);
        assign rom[g] = ENTRY;
    end

    logic [CW-1:0]           cnt_q,  cnt_d;
    logic [SAMPLE_WIDTH-1:0] sine_q, sine_d;
    logic [SAMPLE_WIDTH-1:0] neg_q,  neg_d;
    logic [CW-1:0]           nxt_idx;
    logic [SAMPLE_WIDTH-1:0] table_val;

`ifdef SINE_GEN_QUARTER_WAVE_EN
    logic [CW-2:0]           q_idx;
    logic                    mirror_neg;

    // The top two phase bits select the quadrant. Quadrants 1 and 3 read the
    // table backwards from N/2. Quadrants 2 and 3 invert the sample around
    // midscale.
    always_comb begin
        nxt_idx    = cnt_q + ONE_C;
        q_idx      = '0;
        mirror_neg = 1'b0;
        case (nxt_idx[CW-1 -: 2])
            2'b00: q_idx = (CW-1)'(nxt_idx);
            2'b01: q_idx = (CW-1)'(HALF_C - nxt_idx);
            2'b10: begin
                q_idx      = (CW-1)'(nxt_idx - HALF_C);
                mirror_neg = 1'b1;
            end
            default: begin
                q_idx      = (CW-1)'(ZERO_C - nxt_idx);
                mirror_neg = 1'b1;
            end
        endcase
        table_val = mirror_neg ? (ZERO_W - rom[q_idx]) : rom[q_idx];
    end
`else
    always_comb begin
        nxt_idx   = cnt_q + ONE_C;
        table_val = rom[nxt_idx];
    end
`endif

    // The next sample is looked up with the next phase index, so the sample
    // and the counter change on the same edge.
    always_comb begin
        cnt_d  = cnt_q;
        sine_d = sine_q;
        if (rst) begin
            cnt_d  = ZERO_C;
            sine_d = MID_W;
        end else if (en) begin
            cnt_d  = nxt_idx;
            sine_d = table_val;
        end
        // 2^W - x in W bits. Samples never reach 0, so the result never wraps.
        neg_d = ZERO_W - sine_d;
    end

    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        sine_q <= sine_d;
        neg_q  <= neg_d;
    end

    assign signal_cnt   = cnt_q;
    assign sine_out     = sine_q;
    assign neg_sine_out = neg_q;

endmodule

// File: tb/tb_sine_generator.sv
// Purpose : Self-checking bench for sine_generator at the default size (256x12)
//           and the small size (16x8). Both instances share the same stimulus.
// Latency : The expected outputs for each edge are queued when the edge occurs
//           and popped on the following falling edge.
// Backpressure: none
module tb_sine_generator;
    localparam int N1 = 256;
    localparam int W1 = 12;
    localparam int N2 = 16;
    localparam int W2 = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [W1-1:0] s1, n1;
    logic [7:0]    c1;
    logic [W2-1:0] s2, n2;
    logic [3:0]    c2;

    always #5 clk = ~clk;

    sine_generator #(.SAMPLE_NUMBER(N1), .SAMPLE_WIDTH(W1)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .sine_out(s1), .neg_sine_out(n1), .signal_cnt(c1)
    );

    sine_generator #(.SAMPLE_NUMBER(N2), .SAMPLE_WIDTH(W2)) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .sine_out(s2), .neg_sine_out(n2), .signal_cnt(c2)
    );

    typedef struct {
        int cnt1;
        int sin1;
        int cnt2;
        int sin2;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt1   = 0;
    int   m_cnt2   = 0;
    bit   m_known  = 1'b0;

    // Reference sample: M + round(A*sin(2*pi*n/N)), rounding half away from zero.
    function automatic int t_val(input int n, input int nn, input int w);
        int  m;
        int  rn;
        real r;
        m = 1 << (w - 1);
        r = real'(m - 1) * $sin(2.0 * 3.14159265358979323846 * real'(n) / real'(nn));
        if (r >= 0.0) rn = $rtoi(r + 0.5);
        else          rn = -$rtoi(0.5 - r);
        return m + rn;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (time %0t)", name, act, req, $time);
        end
    endtask

    // Monitor: on each falling edge, compares the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cnt_a",  32'(c1), e.cnt1);
            check("sine_a", 32'(s1), e.sin1);
            check("neg_a",  32'(n1), (1 << W1) - e.sin1);
            check("sum_a",  32'(s1) + 32'(n1), 1 << W1);
            check("cnt_b",  32'(c2), e.cnt2);
            check("sine_b", 32'(s2), e.sin2);
            check("neg_b",  32'(n2), (1 << W2) - e.sin2);
            check("sum_b",  32'(s2) + 32'(n2), 1 << W2);
            case (e.cnt1)
                0:   check("pt_a_0",   32'(s1), 2048);
                1:   check("pt_a_1",   32'(s1), 2098);
                64:  begin
                    check("pt_a_64",  32'(s1), 4095);
                    check("pt_a_64n", 32'(n1), 1);
                end
                128: check("pt_a_128", 32'(s1), 2048);
                192: begin
                    check("pt_a_192",  32'(s1), 1);
                    check("pt_a_192n", 32'(n1), 4095);
                end
                255: check("pt_a_255", 32'(s1), 1998);
                default: ;
            endcase
            case (e.cnt2)
                4:  check("pt_b_4",  32'(s2), 255);
                12: check("pt_b_12", 32'(s2), 1);
                default: ;
            endcase
        end
    end

    // Drives one clock edge. The model applies the same inputs at that edge,
    // and the resulting expectation is queued for the monitor.
    task automatic cycle(input logic r, input logic e_in);
        exp_t x;
        rst = r;
        en  = e_in;
        @(posedge clk);
        if (r) begin
            m_cnt1  = 0;
            m_cnt2  = 0;
            m_known = 1'b1;
        end else if (e_in && m_known) begin
            m_cnt1 = (m_cnt1 + 1) % N1;
            m_cnt2 = (m_cnt2 + 1) % N2;
        end
        if (m_known) begin
            x.cnt1 = m_cnt1;
            x.sin1 = t_val(m_cnt1, N1, W1);
            x.cnt2 = m_cnt2;
            x.sin2 = t_val(m_cnt2, N2, W2);
            sb.push_back(x);
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        // Reset for two edges, with en held high.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        // One full period returns the phase to 0.
        repeat (N1) cycle(1'b0, 1'b1);
        // Advance to phase 37, then freeze for 10 cycles and resume.
        repeat (37) cycle(1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0);
        // Resume to phase 100, then reset mid-period with en high.
        repeat (63) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (20) cycle(1'b0, 1'b1);
        // Random mix of enables and occasional resets.
        repeat (1500) cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
